// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: register IDs and
// control bits in, stall/flush enables and forwarding selects out.
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] idex_rs1;
    logic [4:0] idex_rs2;
    logic [4:0] idex_rd;
    logic       idex_mem_read;
    logic [4:0] exmem_rd;
    logic       exmem_reg_write;
    logic       exmem_mem_req;
    logic       exmem_pcsrc;
    logic [4:0] memwb_rd;
    logic       memwb_reg_write;
    logic       dmem_ready;
    logic       stall_pc;
    logic       stall_if_id;
    logic       stall_id_ex;
    logic       stall_ex_mem;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       flush_ex_mem;
    logic       flush_mem_wb;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mem_err;
    logic [1:0] state_o;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, idex_rs1, idex_rs2, idex_rd,
               idex_mem_read, exmem_rd, exmem_reg_write, exmem_mem_req, exmem_pcsrc,
               memwb_rd, memwb_reg_write, dmem_ready,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
               fwd_a, fwd_b, mem_err, state_o
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, idex_rs1, idex_rs2, idex_rd,
               idex_mem_read, exmem_rd, exmem_reg_write, exmem_mem_req, exmem_pcsrc,
               memwb_rd, memwb_reg_write, dmem_ready,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
               fwd_a, fwd_b, mem_err, state_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline: load-use bubbles,
// branch redirects, data-memory waits and EX forwarding. Define PIPE_PERF_CNT_EN for perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT     = 16,
    parameter int unsigned LU_STALL_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_events,
    output logic [31:0]        mem_wait_cycles,
`endif
    pipe_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [7:0] TMO      = 8'(MEM_TIMEOUT);
    localparam logic [7:0] LU_LAST  = 8'(LU_STALL_CYCLES - 1);
    localparam bit         LU_MULTI = (LU_STALL_CYCLES > 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       lu, mw, err;
    // stall: {ex_mem, id_ex, if_id, pc}; flush: {mem_wb, ex_mem, id_ex, if_id}
    logic [3:0] stall, flush;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] ex_rd, input logic ex_we,
                                           input logic [4:0] wb_rd, input logic wb_we);
        if (ex_we && ex_rd != '0 && ex_rd == rs)      return 2'b10;
        else if (wb_we && wb_rd != '0 && wb_rd == rs) return 2'b01;
        else                                          return 2'b00;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        lu = bus.idex_mem_read && (bus.idex_rd != '0) &&
             ((bus.id_use_rs1 && bus.idex_rd == bus.id_rs1) ||
              (bus.id_use_rs2 && bus.idex_rd == bus.id_rs2));
        mw = bus.exmem_mem_req && !bus.dmem_ready;
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        stall   = '0;
        flush   = '0;
        err     = 1'b0;
        case (state_q)
            MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    if (pend_q) begin
                        flush   = 4'b0111;
                        pend_d  = 1'b0;
                        state_d = REDIRECT;
                    end else begin
                        // The frozen load in ID_EX may still hazard the ID instruction on release.
                        state_d = RUN;
                        if (lu) begin
                            stall = 4'b0011;
                            flush = 4'b0010;
                            if (LU_MULTI) begin
                                state_d = LU_STALL;
                                cnt_d   = 8'd1;
                            end
                        end
                    end
                end else if (cnt_q == TMO) begin
                    // Abort: EX_MEM becomes a bubble; younger stages hold unless redirected.
                    err   = 1'b1;
                    flush = 4'b1100;
                    if (pend_q) begin
                        flush   = 4'b1111;
                        pend_d  = 1'b0;
                        state_d = REDIRECT;
                    end else begin
                        stall   = 4'b0111;
                        state_d = RUN;
                    end
                end else begin
                    stall = '1;
                    flush = 4'b1000;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (mw) begin
                    stall   = '1;
                    flush   = 4'b1000;
                    cnt_d   = 8'd1;
                    pend_d  = bus.exmem_pcsrc;
                    state_d = MEM_WAIT;
                end else if (state_q == REDIRECT) begin
                    flush   = 4'b0001;
                    state_d = RUN;
                end else if (bus.exmem_pcsrc) begin
                    flush   = 4'b0111;
                    state_d = REDIRECT;
                end else if (state_q == LU_STALL) begin
                    stall = 4'b0011;
                    flush = 4'b0010;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LU_LAST) state_d = RUN;
                end else if (lu) begin
                    stall = 4'b0011;
                    flush = 4'b0010;
                    if (LU_MULTI) begin
                        state_d = LU_STALL;
                        cnt_d   = 8'd1;
                    end
                end
            end
        endcase
    end

    assign bus.stall_pc     = stall[0] & ~rst;
    assign bus.stall_if_id  = stall[1] & ~rst;
    assign bus.stall_id_ex  = stall[2] & ~rst;
    assign bus.stall_ex_mem = stall[3] & ~rst;
    assign bus.flush_if_id  = flush[0] & ~rst;
    assign bus.flush_id_ex  = flush[1] & ~rst;
    assign bus.flush_ex_mem = flush[2] & ~rst;
    assign bus.flush_mem_wb = flush[3] & ~rst;
    assign bus.mem_err      = err & ~rst;
    assign bus.state_o      = state_q;
    assign bus.fwd_a = fwd_sel(bus.idex_rs1, bus.exmem_rd, bus.exmem_reg_write,
                               bus.memwb_rd, bus.memwb_reg_write);
    assign bus.fwd_b = fwd_sel(bus.idex_rs2, bus.exmem_rd, bus.exmem_reg_write,
                               bus.memwb_rd, bus.memwb_reg_write);

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles    <= '0;
            flush_events    <= '0;
            mem_wait_cycles <= '0;
        end else begin
            if (stall[0])               stall_cycles    <= stall_cycles + 32'd1;
            if (state_d == REDIRECT)    flush_events    <= flush_events + 32'd1;
            if (state_q == MEM_WAIT)    mem_wait_cycles <= mem_wait_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl: two configurations share the stimulus and
// are compared every cycle against a phase-based behavioural model.
module tb_pipe_hazard_ctrl;
    logic clk, rst;
    logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic id_use_rs1, id_use_rs2, idex_mem_read, exmem_reg_write, exmem_mem_req;
    logic exmem_pcsrc, memwb_reg_write, dmem_ready;
    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl_if ifa();
    pipe_hazard_ctrl_if ifb();

    assign ifa.id_rs1 = id_rs1, ifa.id_rs2 = id_rs2, ifa.id_use_rs1 = id_use_rs1,
           ifa.id_use_rs2 = id_use_rs2, ifa.idex_rs1 = idex_rs1, ifa.idex_rs2 = idex_rs2,
           ifa.idex_rd = idex_rd, ifa.idex_mem_read = idex_mem_read, ifa.exmem_rd = exmem_rd,
           ifa.exmem_reg_write = exmem_reg_write, ifa.exmem_mem_req = exmem_mem_req,
           ifa.exmem_pcsrc = exmem_pcsrc, ifa.memwb_rd = memwb_rd,
           ifa.memwb_reg_write = memwb_reg_write, ifa.dmem_ready = dmem_ready;
    assign ifb.id_rs1 = id_rs1, ifb.id_rs2 = id_rs2, ifb.id_use_rs1 = id_use_rs1,
           ifb.id_use_rs2 = id_use_rs2, ifb.idex_rs1 = idex_rs1, ifb.idex_rs2 = idex_rs2,
           ifb.idex_rd = idex_rd, ifb.idex_mem_read = idex_mem_read, ifb.exmem_rd = exmem_rd,
           ifb.exmem_reg_write = exmem_reg_write, ifb.exmem_mem_req = exmem_mem_req,
           ifb.exmem_pcsrc = exmem_pcsrc, ifb.memwb_rd = memwb_rd,
           ifb.memwb_reg_write = memwb_reg_write, ifb.dmem_ready = dmem_ready;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .LU_STALL_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pipe_hazard_ctrl #(.MEM_TIMEOUT(6), .LU_STALL_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic [3:0] a_stall, a_flush, b_stall, b_flush;
    assign a_stall = {ifa.stall_ex_mem, ifa.stall_id_ex, ifa.stall_if_id, ifa.stall_pc};
    assign a_flush = {ifa.flush_mem_wb, ifa.flush_ex_mem, ifa.flush_id_ex, ifa.flush_if_id};
    assign b_stall = {ifb.stall_ex_mem, ifb.stall_id_ex, ifb.stall_if_id, ifb.stall_pc};
    assign b_flush = {ifb.flush_mem_wb, ifb.flush_ex_mem, ifb.flush_id_ex, ifb.flush_if_id};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: bubbles still owed, waiting on memory with elapsed frozen cycles,
    // branch remembered across the wait, and the one-cycle redirect tail.
    typedef struct {
        int bub;
        bit waiting;
        int wn;
        bit pend;
        bit tail;
    } mst_t;

    typedef struct packed {
        logic [3:0] stall;
        logic [3:0] flush;
        logic       err;
        logic [1:0] st;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    mst_t sA = '{default: 0};
    mst_t nA = '{default: 0};
    mst_t sB = '{default: 0};
    mst_t nB = '{default: 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (exmem_reg_write && exmem_rd == rs) return 2'b10;
        if (memwb_reg_write && memwb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model(input mst_t s, input int tmo, input int lus,
                         output exp_t e, output mst_t n);
        bit lu_h, mw_h;
        lu_h = idex_mem_read && idex_rd != 0 &&
               ((id_use_rs1 && idex_rd == id_rs1) || (id_use_rs2 && idex_rd == id_rs2));
        mw_h = exmem_mem_req && !dmem_ready;
        e = '0;
        n = s;
        e.fa = fwd_ref(idex_rs1);
        e.fb = fwd_ref(idex_rs2);
        if (rst) begin
            n = '{default: 0};
        end else begin
            e.st = s.waiting ? 2'd2 : s.tail ? 2'd3 : (s.bub > 0) ? 2'd1 : 2'd0;
            if (s.waiting) begin
                if (dmem_ready) begin
                    n.waiting = 0;
                    if (s.pend) begin
                        e.flush = 4'b0111; n.pend = 0; n.tail = 1;
                    end else if (lu_h) begin
                        e.stall = 4'b0011; e.flush = 4'b0010; n.bub = lus - 1;
                    end
                end else if (s.wn == tmo) begin
                    e.err = 1'b1;
                    n.waiting = 0;
                    if (s.pend) begin
                        e.flush = 4'b1111; n.pend = 0; n.tail = 1;
                    end else begin
                        e.stall = 4'b0111; e.flush = 4'b1100;
                    end
                end else begin
                    e.stall = 4'b1111; e.flush = 4'b1000; n.wn = s.wn + 1;
                end
            end else begin
                n.tail = 0;
                if (mw_h) begin
                    e.stall = 4'b1111; e.flush = 4'b1000;
                    n.waiting = 1; n.wn = 1; n.pend = exmem_pcsrc; n.bub = 0;
                end else if (s.tail) begin
                    e.flush = 4'b0001;
                end else if (exmem_pcsrc) begin
                    e.flush = 4'b0111; n.tail = 1; n.bub = 0;
                end else if (s.bub > 0) begin
                    e.stall = 4'b0011; e.flush = 4'b0010; n.bub = s.bub - 1;
                end else if (lu_h) begin
                    e.stall = 4'b0011; e.flush = 4'b0010; n.bub = lus - 1;
                end
            end
        end
    endtask

    task automatic check_dut(input string tag, input exp_t e, input logic [3:0] st,
                             input logic [3:0] fl, input logic err, input logic [1:0] state,
                             input logic [1:0] fa, input logic [1:0] fb);
        chk({tag, "_stall"}, st, e.stall);
        chk({tag, "_flush"}, fl, e.flush);
        chk({tag, "_mem_err"}, err, e.err);
        chk({tag, "_state"}, state, e.st);
        chk({tag, "_fwd_a"}, fa, e.fa);
        chk({tag, "_fwd_b"}, fb, e.fb);
    endtask

    always @(negedge clk) begin
        exp_t eA, eB;
        model(sA, 4, 1, eA, nA);
        model(sB, 6, 3, eB, nB);
        check_dut("A", eA, a_stall, a_flush, ifa.mem_err, ifa.state_o, ifa.fwd_a, ifa.fwd_b);
        check_dut("B", eB, b_stall, b_flush, ifb.mem_err, ifb.state_o, ifb.fwd_a, ifb.fwd_b);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sA = '{default: 0};
            sB = '{default: 0};
        end else begin
            sA = nA;
            sB = nB;
        end
    end

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0; idex_mem_read = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_mem_req = 0; exmem_pcsrc = 0;
        memwb_rd = 0; memwb_reg_write = 0; dmem_ready = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            cyc();
            idle();
        end
    endtask

    task automatic rand_inputs();
        id_rs1 = 5'($urandom_range(0, 3));
        id_rs2 = 5'($urandom_range(0, 3));
        id_use_rs1 = 1'($urandom_range(0, 1));
        id_use_rs2 = 1'($urandom_range(0, 1));
        idex_rs1 = 5'($urandom_range(0, 3));
        idex_rs2 = 5'($urandom_range(0, 3));
        idex_rd = 5'($urandom_range(0, 3));
        idex_mem_read = 1'($urandom_range(0, 1));
        exmem_rd = 5'($urandom_range(0, 3));
        exmem_reg_write = 1'($urandom_range(0, 1));
        exmem_mem_req = ($urandom_range(0, 9) < 3);
        exmem_pcsrc = ($urandom_range(0, 9) == 0);
        memwb_rd = 5'($urandom_range(0, 3));
        memwb_reg_write = 1'($urandom_range(0, 1));
        dmem_ready = ($urandom_range(0, 9) < 4);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        chk("reset_state_a", ifa.state_o, 2'd0);
        chk("reset_stall_a", a_stall, 4'b0000);
        chk("reset_flush_b", b_flush, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Load-use bubble, then MEM_WB forward of the loaded value
        cyc(); idle();
        idex_mem_read = 1; idex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        #1;
        chk("lu_stall_a", a_stall, 4'b0011);
        chk("lu_flush_a", a_flush, 4'b0010);
        chk("lu_state_b", ifb.state_o, 2'd0);
        cyc(); idle();
        idex_rs1 = 5; memwb_rd = 5; memwb_reg_write = 1;
        #1;
        chk("lu_fwd_a", ifa.fwd_a, 2'b01);
        chk("lu_done_stall_a", a_stall, 4'b0000);
        chk("lu_extra_state_b", ifb.state_o, 2'd1);
        gap(3);

        // Forwarding priority and x0
        cyc(); idle();
        exmem_rd = 7; exmem_reg_write = 1; memwb_rd = 7; memwb_reg_write = 1;
        idex_rs1 = 7; idex_rs2 = 3;
        #1;
        chk("fwd_double_a", ifa.fwd_a, 2'b10);
        chk("fwd_nomatch_b", ifa.fwd_b, 2'b00);
        exmem_rd = 0; memwb_rd = 0; idex_rs1 = 0;
        #1;
        chk("fwd_x0_a", ifa.fwd_a, 2'b00);

        // Branch redirect
        cyc(); idle();
        exmem_pcsrc = 1;
        #1;
        chk("br_flush", a_flush, 4'b0111);
        chk("br_stall", a_stall, 4'b0000);
        cyc(); idle();
        #1;
        chk("br_tail_state", ifa.state_o, 2'd3);
        chk("br_tail_flush", a_flush, 4'b0001);
        cyc(); idle();
        #1;
        chk("br_back_state", ifa.state_o, 2'd0);
        chk("br_back_flush", a_flush, 4'b0000);

        // Memory wait of three frozen cycles, released on ready
        cyc(); idle();
        exmem_mem_req = 1;
        #1;
        chk("mw_entry_stall", a_stall, 4'b1111);
        chk("mw_entry_flush", a_flush, 4'b1000);
        repeat (2) begin
            cyc();
            #1;
            chk("mw_wait_state", ifa.state_o, 2'd2);
            chk("mw_wait_stall", a_stall, 4'b1111);
        end
        cyc(); dmem_ready = 1;
        #1;
        chk("mw_release_stall", a_stall, 4'b0000);
        chk("mw_release_flush", a_flush, 4'b0000);
        cyc(); idle();
        #1;
        chk("mw_done_state", ifa.state_o, 2'd0);

        // Timeout with a pending branch
        cyc(); idle();
        exmem_mem_req = 1; exmem_pcsrc = 1;
        #1;
        chk("to_entry_err", ifa.mem_err, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            #1;
            chk("to_wait_err", ifa.mem_err, 1'b0);
        end
        cyc();
        #1;
        chk("to_err_pulse", ifa.mem_err, 1'b1);
        chk("to_err_flush", a_flush, 4'b1111);
        cyc(); idle();
        #1;
        chk("to_redirect_state", ifa.state_o, 2'd3);
        chk("to_redirect_flush", a_flush, 4'b0001);
        chk("to_err_cleared", ifa.mem_err, 1'b0);
        gap(5);

        // Asynchronous reset in the middle of a memory wait
        cyc(); idle();
        exmem_mem_req = 1;
        cyc();
        cyc();
        #1;
        chk("arst_pre_state", ifa.state_o, 2'd2);
        #1 rst = 1'b1;
        #1;
        chk("arst_state_a", ifa.state_o, 2'd0);
        chk("arst_stall_a", a_stall, 4'b0000);
        chk("arst_state_b", ifb.state_o, 2'd0);
        chk("arst_stall_b", b_stall, 4'b0000);
        idle();
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (3000) begin
            cyc();
            rst = 1'b0;
            rand_inputs();
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
            end
        end
        cyc();
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
